// File: rtl/ddr_out_serializer.sv
// Parallel-to-DDR serializer: WIDTH-bit words in over valid/ready, 2 bits per clk out (MSB first).
// Optional DDR_OUT_SERIALIZER_LSB_FIRST_EN adds a per-word lsb_first order select.
module ddr_out_serializer #(
  parameter int         WIDTH      = 16,
  parameter logic [0:0] IDLE_VALUE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
`ifdef DDR_OUT_SERIALIZER_LSB_FIRST_EN
  input  logic             lsb_first,
`endif
  output logic             in_ready,
  output logic [1:0]       ddr_d,
  output logic             ddr_oe,
  output logic             busy
);

  localparam int              PAIRS = WIDTH / 2;
  localparam int              CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0]   LAST  = CW'(PAIRS - 1);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             lsb_nxt;
  logic             take;

  // Bit pair presented for a shifter image; [0] is the earlier half-period.
  function automatic logic [1:0] pair_of(input logic [WIDTH-1:0] s, input logic lsb);
    return lsb ? {s[1], s[0]} : {s[WIDTH-2], s[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_of(input logic [WIDTH-1:0] s, input logic lsb);
    return lsb ? (s >> 2) : (s << 2);
  endfunction

`ifdef DDR_OUT_SERIALIZER_LSB_FIRST_EN
  logic lsb_q;
  assign lsb_nxt = take ? lsb_first : lsb_q;
`else
  assign lsb_nxt = 1'b0;
`endif

  assign take = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    shreg_nxt = shreg;
    if (take) begin
      shreg_nxt = in_data;
      count_nxt = LAST;
      state_nxt = SHIFT;
    end else if (state == SHIFT) begin
      if (count != '0) begin
        shreg_nxt = shift_of(shreg, lsb_nxt);
        count_nxt = count - CW'(1);
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Outputs are registered from next-state so they align with the shifter contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      shreg    <= '0;
`ifdef DDR_OUT_SERIALIZER_LSB_FIRST_EN
      lsb_q    <= 1'b0;
`endif
      in_ready <= 1'b1;
      ddr_d    <= {2{IDLE_VALUE[0]}};
      ddr_oe   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      shreg    <= shreg_nxt;
`ifdef DDR_OUT_SERIALIZER_LSB_FIRST_EN
      lsb_q    <= lsb_nxt;
`endif
      in_ready <= (state_nxt == IDLE) || (count_nxt == '0);
      ddr_d    <= (state_nxt == SHIFT) ? pair_of(shreg_nxt, lsb_nxt) : {2{IDLE_VALUE[0]}};
      ddr_oe   <= (state_nxt == SHIFT);
      busy     <= (state_nxt == SHIFT);
    end
  end

endmodule

// File: tb/tb_ddr_out_serializer.sv
// Self-checking bench for ddr_out_serializer (WIDTH=8, IDLE_VALUE=1) against a pair-queue model.
module tb_ddr_out_serializer;
  localparam int         W      = 8;
  localparam logic [1:0] IDLE_D = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   ddr_d;
  logic         ddr_oe;
  logic         busy;
`ifdef DDR_OUT_SERIALIZER_LSB_FIRST_EN
  logic         lsb_first;
`endif

  ddr_out_serializer #(.WIDTH(W), .IDLE_VALUE(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
`ifdef DDR_OUT_SERIALIZER_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .in_ready (in_ready),
    .ddr_d    (ddr_d),
    .ddr_oe   (ddr_oe),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] q[$];
  logic       exp_ready;
  logic [1:0] exp_d;
  logic       exp_oe;
  int         oe_seen;
  logic [23:0] stream;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // A word becomes WIDTH/2 bit pairs in transmit order; element [0] is the earlier bit.
  task automatic push_word(input logic [W-1:0] w, input bit lsb);
    for (int k = 0; k < W/2; k++) begin
      if (lsb) q.push_back({w[2*k+1], w[2*k]});
      else     q.push_back({w[W-2-2*k], w[W-1-2*k]});
    end
  endtask

  task automatic cycle(input bit v, input logic [W-1:0] d, input bit lsb);
    bit acc;
    in_valid = v;
    in_data  = d;
`ifdef DDR_OUT_SERIALIZER_LSB_FIRST_EN
    lsb_first = lsb;
`endif
    acc = v && exp_ready;
    @(posedge clk);
    if (acc) push_word(d, lsb);
    if (q.size() > 0) begin
      exp_d  = q.pop_front();
      exp_oe = 1'b1;
    end else begin
      exp_d  = IDLE_D;
      exp_oe = 1'b0;
    end
    exp_ready = (q.size() == 0);
    #1;
    if (ddr_oe === 1'b1) oe_seen++;
    stream = {stream[21:0], ddr_d[0], ddr_d[1]};
    check("ddr_d", 8'(ddr_d), 8'(exp_d));
    check("ddr_oe", 8'(ddr_oe), 8'(exp_oe));
    check("busy", 8'(busy), 8'(exp_oe));
    check("in_ready", 8'(in_ready), 8'(exp_ready));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_d"}, 8'(ddr_d), 8'(IDLE_D));
    check({tag, "_oe"}, 8'(ddr_oe), 8'd0);
    check({tag, "_busy"}, 8'(busy), 8'd0);
    check({tag, "_rdy"}, 8'(in_ready), 8'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef DDR_OUT_SERIALIZER_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    exp_ready = 1'b1;
    oe_seen   = 0;
    stream    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, '0, 0);
    check_idle("post_reset");

    // Single word, then a pulse while not ready that must be ignored.
    cycle(1, 8'hA5, 0);
    cycle(1, 8'h3C, 0);
    cycle(0, 8'h3C, 0);
    cycle(0, '0, 0);
    repeat (2) cycle(0, '0, 0);

    // Back-to-back words with in_valid held high.
    oe_seen = 0;
    repeat (4) cycle(1, 8'hFF, 0);
    repeat (4) cycle(1, 8'h00, 0);
    repeat (4) cycle(1, 8'hC3, 0);
    check("stream_oe_cycles", 8'(oe_seen), 8'd12);
    check("stream_bits_hi", stream[23:16], 8'hFF);
    check("stream_bits_mid", stream[15:8], 8'h00);
    check("stream_bits_lo", stream[7:0], 8'hC3);
    cycle(0, '0, 0);

    // Asynchronous reset in the second cycle of a word.
    cycle(1, 8'hA5, 0);
    cycle(0, '0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    q.delete();
    exp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_idle("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 8'h3C, 0);
    repeat (4) cycle(0, '0, 0);

`ifdef DDR_OUT_SERIALIZER_LSB_FIRST_EN
    repeat (4) cycle(1, 8'hA5, 1);
    repeat (4) cycle(1, 8'h01, 0);
    cycle(0, '0, 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      bit             v;
      logic [W-1:0]   d;
      bit             l;
      v = 1'($urandom_range(0, 1));
      d = W'($urandom);
`ifdef DDR_OUT_SERIALIZER_LSB_FIRST_EN
      l = 1'($urandom_range(0, 1));
`else
      l = 1'b0;
`endif
      cycle(v, d, l);
    end
    repeat (5) cycle(0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_out_serializer.md
Name: ddr_out_serializer

Overview:
- Parallel-to-DDR serializer that sits directly upstream of the DDR output cell. It consumes WIDTH-bit words over a valid/ready handshake and presents 2 bits per clk on ddr_d[1:0], MSB first.
- ddr_d[0] carries the earlier bit: it is driven in the first half-period after the cell registers it. ddr_d[1] carries the later bit.
- Also produces a pad output-enable aligned with the data and a busy status. Used by PSRAM/display-style DDR transmit paths.

Parameters:
- WIDTH, 16, word width in bits; must be even and >= 2.
- IDLE_VALUE, 0, bit value driven on both ddr_d lanes when no word is being shifted.

Ports:
- clk  input  1  clock; ddr_d is sampled by the downstream DDR cell on posedge clk.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  WIDTH  word to serialize; bit WIDTH-1 is transmitted first.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  serializer accepts in_data this cycle.
- ddr_d  output  2  bit pair to the DDR cell; [0] is the first half-period, [1] the second.
- ddr_oe  output  1  high while ddr_d carries word data; same timing as ddr_d.
- busy  output  1  high while a word is in the shifter.

Behaviour:
- States:
  - IDLE: shifter empty.
  - SHIFT: count holds the pairs remaining minus 1.
  - count width is max(1, $clog2(WIDTH/2)).
- Transfer: an input word transfers on a posedge where in_valid && in_ready.
- in_ready:
  - Equals (state==IDLE) || (state==SHIFT && count==0).
  - Depends on registered state only, never on in_valid.
- On transfer:
  - shreg <= in_data, count <= WIDTH/2-1, state <= SHIFT.
  - This also applies when the last pair of the previous word is being presented, which gives gapless back-to-back words.
- In SHIFT without transfer:
  - If count != 0: shreg shifts left by 2 (zero fill) and count decrements.
  - If count == 0: state <= IDLE.
- Outputs in SHIFT:
  - ddr_d[0] = shreg[WIDTH-1], ddr_d[1] = shreg[WIDTH-2].
  - ddr_oe = 1, busy = 1.
- Outputs in IDLE:
  - ddr_d = {2{IDLE_VALUE[0]}}, ddr_oe = 0, busy = 0.
- All outputs are driven directly from flops (state/shreg); there are no combinational paths from in_* to ddr_*.
- Latency: word accepted at posedge N → pair 0 on ddr_d during cycle N..N+1, sampled by the DDR cell at posedge N+1. Pair k is sampled at N+1+k.
- A word occupies exactly WIDTH/2 cycles. A continuous in_valid yields 100% throughput with ddr_oe held high.
- WIDTH == 2:
  - count is fixed at 0, so in_ready is always high.
  - Every accepted word is a single cycle.
- Reset:
  - Asserting rst_n low at any point, including mid-word, forces IDLE immediately.
  - During reset: shreg = 0, count = 0, in_ready = 1, ddr_oe = 0, busy = 0, ddr_d = idle value.
  - A partially sent word is discarded, not resumed.
- in_data/in_valid are ignored while in_ready is low; the source must hold them.

Optional Feature:
- Macro DDR_OUT_SERIALIZER_LSB_FIRST_EN.
- When defined:
  - Adds a 1-bit input lsb_first, sampled on each transfer and held for that word.
  - If the sampled value is 1: ddr_d[0] = shreg[0], ddr_d[1] = shreg[1], and shreg shifts right by 2.
  - If the sampled value is 0: behaviour is identical to the MSB-first default.
- When undefined: the port is absent and the order is always MSB first.

Test Plan:
- Reset release, then idle with IDLE_VALUE=1 → ddr_d=2'b11, ddr_oe=0, busy=0, in_ready=1.
- WIDTH=8, one transfer of in_data=8'hA5 at posedge N → pairs (ddr_d[0],ddr_d[1]) = (1,0),(1,0),(0,1),(0,1) in cycles N..N+3. ddr_oe is high exactly 4 cycles. in_ready is low during cycles N..N+2 and high in cycle N+3.
- WIDTH=8, in_valid held high with words 8'hFF, 8'h00, 8'hC3 → 12 consecutive oe cycles, no idle gap; the data stream is 11111111 00000000 11000011.
- rst_n asserted in cycle N+1 of an 8'hA5 word → ddr_oe=0 and ddr_d=idle immediately (asynchronously). After release, the next word starts from its own MSB.
- in_valid pulsed while in_ready=0 (mid-word), then dropped → that pulse is not accepted, and IDLE follows the current word.
- With DDR_OUT_SERIALIZER_LSB_FIRST_EN, lsb_first=1, 8'hA5 → pairs (1,0),(1,0),(0,1),(0,1) in LSB order, i.e. bit stream 10100101 reversed = 1010_0101 LSB-first. Then lsb_first=0 with 8'h01 → pairs (0,0),(0,0),(0,0),(0,1).
